// File: rtl/writeback_stage_pkg.sv
// Shared CPU types for the MEM/WB boundary: word/register types, writeback
// source and load-size encodings, and the latched pipeline bundle.
package writeback_stage_pkg;

    localparam int WORD_W = 32;
    localparam int REG_AW = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_AW-1:0] regbits_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_LUI  = 2'd3
    } wbsrc_t;

    typedef enum logic [1:0] {
        LS_WORD = 2'd0,
        LS_HALF = 2'd1,
        LS_BYTE = 2'd2
    } lsize_t;

    typedef struct packed {
        logic        valid;
        logic        regwen;
        regbits_t    wsel;
        wbsrc_t      wbsrc;
        lsize_t      lsize;
        logic        lsigned;
        word_t       aluout;
        word_t       dload;
        word_t       pc4;
        logic [15:0] imm16;
        logic        halt;
    } mem_wb_t;

    // Widen a sub-word lane, replicating its top bit when signed.
    function automatic word_t extend_lane(input logic [15:0] lane, input logic is_byte,
                                          input logic sgn);
        word_t res;
        if (is_byte) begin
            res = {{24{sgn & lane[7]}}, lane[7:0]};
        end else begin
            res = {{16{sgn & lane[15]}}, lane};
        end
        return res;
    endfunction

endpackage

// File: rtl/writeback_stage_load_extract.sv
// Selects the addressed byte/halfword lane from a raw load word and extends it.
module writeback_stage_load_extract
    import writeback_stage_pkg::*;
(
    input  word_t       dload,
    input  logic [1:0]  addr,
    input  lsize_t      lsize,
    input  logic        lsigned,
    output word_t       data
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Lane selection and extension.
    always_comb begin
        half_s = addr[1] ? dload[31:16] : dload[15:0];
        case (addr)
            2'd0:    byte_s = dload[7:0];
            2'd1:    byte_s = dload[15:8];
            2'd2:    byte_s = dload[23:16];
            default: byte_s = dload[31:24];
        endcase
        case (lsize)
            LS_HALF: data = extend_lane(half_s, 1'b0, lsigned);
            LS_BYTE: data = extend_lane({8'h00, byte_s}, 1'b1, lsigned);
            default: data = dload;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline latch, writeback mux, sticky halt and retire counter.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              wb_en,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_regwen,
    input  logic [REG_AW-1:0] mem_wsel,
    input  logic [1:0]        mem_wbsrc,
    input  logic [1:0]        mem_lsize,
    input  logic              mem_lsigned,
    input  logic [WORD_W-1:0] mem_aluout,
    input  logic [WORD_W-1:0] mem_dload,
    input  logic [WORD_W-1:0] mem_pc4,
    input  logic [15:0]       mem_imm16,
    input  logic              mem_halt,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_wsel,
    output logic [WORD_W-1:0] rf_wdat,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_wsel,
    output logic [WORD_W-1:0] fwd_wdat,
    output logic              halt,
    output logic [CNT_W-1:0]  retire_cnt
);

    mem_wb_t            latch_r;
    mem_wb_t            next_s;
    logic               halt_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               take_s;
    logic               wen_s;
    word_t              load_s;
    word_t              value_s;
    word_t              wdat_s;

    // A real instruction retires only when captured unflushed before halt.
    assign take_s = ~flush & wb_en & mem_valid & ~halt_r;

    // Next latch contents: bubble, new bundle, or hold.
    always_comb begin
        next_s = latch_r;
        if (flush) begin
            next_s = {$bits(mem_wb_t){1'b0}};
        end else if (wb_en) begin
            if (halt_r) begin
                next_s = {$bits(mem_wb_t){1'b0}};
            end else begin
                next_s.valid   = mem_valid;
                next_s.regwen  = mem_regwen;
                next_s.wsel    = mem_wsel;
                next_s.wbsrc   = wbsrc_t'(mem_wbsrc);
                next_s.lsize   = lsize_t'(mem_lsize);
                next_s.lsigned = mem_lsigned;
                next_s.aluout  = mem_aluout;
                next_s.dload   = mem_dload;
                next_s.pc4     = mem_pc4;
                next_s.imm16   = mem_imm16;
                next_s.halt    = mem_halt;
            end
        end else begin
            next_s = latch_r;
        end
    end

    // Pipeline latch, sticky halt and retire counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            latch_r <= {$bits(mem_wb_t){1'b0}};
            halt_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            latch_r <= next_s;
            halt_r  <= halt_r | (take_s & mem_halt);
            if (take_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    writeback_stage_load_extract u_load_extract (
        .dload   (latch_r.dload),
        .addr    (latch_r.aluout[1:0]),
        .lsize   (latch_r.lsize),
        .lsigned (latch_r.lsigned),
        .data    (load_s)
    );

    // Write enable and source mux; data forced to zero when not writing so
    // the forwarding comparators never see stale values.
    always_comb begin
        wen_s = latch_r.valid & latch_r.regwen & (latch_r.wsel != {REG_AW{1'b0}})
              & ~latch_r.halt;
        case (latch_r.wbsrc)
            WB_ALU:  value_s = latch_r.aluout;
            WB_LOAD: value_s = load_s;
            WB_PC4:  value_s = latch_r.pc4;
            WB_LUI:  value_s = {latch_r.imm16, 16'h0000};
            default: value_s = latch_r.aluout;
        endcase
        if (wen_s) begin
            wdat_s = value_s;
        end else begin
            wdat_s = {WORD_W{1'b0}};
        end
    end

    assign rf_wen     = wen_s;
    assign rf_wsel    = latch_r.wsel;
    assign rf_wdat    = wdat_s;
    assign fwd_valid  = wen_s;
    assign fwd_wsel   = latch_r.wsel;
    assign fwd_wdat   = wdat_s;
    assign halt       = halt_r;
    assign retire_cnt = cnt_r;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a behavioural reference model.
module tb_writeback_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        wb_en, flush, mem_valid, mem_regwen, mem_lsigned, mem_halt;
    logic [4:0]  mem_wsel;
    logic [1:0]  mem_wbsrc, mem_lsize;
    logic [31:0] mem_aluout, mem_dload, mem_pc4;
    logic [15:0] mem_imm16;
    logic        rf_wen, fwd_valid, halt;
    logic [4:0]  rf_wsel, fwd_wsel;
    logic [31:0] rf_wdat, fwd_wdat, retire_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the write port must show.
    logic        m_wen  = 1'b0;
    logic [4:0]  m_wsel = 5'd0;
    logic [31:0] m_wdat = 32'd0;
    logic        m_halt = 1'b0;
    logic [31:0] m_cnt  = 32'd0;

    writeback_stage dut (
        .CLK(CLK), .nRST(nRST), .wb_en(wb_en), .flush(flush),
        .mem_valid(mem_valid), .mem_regwen(mem_regwen), .mem_wsel(mem_wsel),
        .mem_wbsrc(mem_wbsrc), .mem_lsize(mem_lsize), .mem_lsigned(mem_lsigned),
        .mem_aluout(mem_aluout), .mem_dload(mem_dload), .mem_pc4(mem_pc4),
        .mem_imm16(mem_imm16), .mem_halt(mem_halt),
        .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
        .fwd_valid(fwd_valid), .fwd_wsel(fwd_wsel), .fwd_wdat(fwd_wdat),
        .halt(halt), .retire_cnt(retire_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Value the instruction should write, computed arithmetically.
    function automatic logic [31:0] model_val(input logic [1:0] src, input logic [1:0] sz,
                                              input logic sg, input logic [31:0] alu,
                                              input logic [31:0] dl, input logic [31:0] pc,
                                              input logic [15:0] im);
        logic [31:0] v;
        int sh;
        case (src)
            2'd0: v = alu;
            2'd2: v = pc;
            2'd3: v = {im, 16'h0000};
            default: begin
                if (sz == 2'd1) begin
                    sh = (alu[1] ? 16 : 0);
                    v = (dl >> sh) & 32'h0000FFFF;
                    if (sg && v[15]) v = v | 32'hFFFF0000;
                end else if (sz == 2'd2) begin
                    sh = 8 * int'(alu[1:0]);
                    v = (dl >> sh) & 32'h000000FF;
                    if (sg && v[7]) v = v | 32'hFFFFFF00;
                end else begin
                    v = dl;
                end
            end
        endcase
        return v;
    endfunction

    // Model update at each capture edge.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_wen = 1'b0; m_wsel = 5'd0; m_wdat = 32'd0; m_halt = 1'b0; m_cnt = 32'd0;
        end else if (flush || (wb_en && m_halt)) begin
            m_wen = 1'b0; m_wsel = 5'd0; m_wdat = 32'd0;
        end else if (wb_en) begin
            m_wsel = mem_wsel;
            m_wen  = mem_valid && mem_regwen && (mem_wsel != 5'd0) && !mem_halt;
            m_wdat = m_wen ? model_val(mem_wbsrc, mem_lsize, mem_lsigned, mem_aluout,
                                       mem_dload, mem_pc4, mem_imm16) : 32'd0;
            if (mem_valid) begin
                m_cnt  = m_cnt + 32'd1;
                m_halt = m_halt | mem_halt;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        chk("rf_wen", {31'd0, rf_wen}, {31'd0, m_wen});
        chk("rf_wsel", {27'd0, rf_wsel}, {27'd0, m_wsel});
        chk("rf_wdat", rf_wdat, m_wdat);
        chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_wen});
        chk("fwd_wsel", {27'd0, fwd_wsel}, {27'd0, m_wsel});
        chk("fwd_wdat", fwd_wdat, m_wdat);
        chk("halt", {31'd0, halt}, {31'd0, m_halt});
        chk("retire_cnt", retire_cnt, m_cnt);
    end

    task automatic issue(input logic fl, input logic we, input logic v, input logic rw,
                         input logic [4:0] ws, input logic [1:0] src, input logic [1:0] sz,
                         input logic sg, input logic [31:0] alu, input logic [31:0] dl,
                         input logic [31:0] pc, input logic [15:0] im, input logic hl);
        flush = fl; wb_en = we; mem_valid = v; mem_regwen = rw; mem_wsel = ws;
        mem_wbsrc = src; mem_lsize = sz; mem_lsigned = sg; mem_aluout = alu;
        mem_dload = dl; mem_pc4 = pc; mem_imm16 = im; mem_halt = hl;
        @(negedge CLK);
    endtask

    localparam logic [31:0] LD = 32'h80FF7F01;

    initial begin
        nRST = 1'b1;
        flush = 1'b0; wb_en = 1'b0; mem_valid = 1'b0; mem_regwen = 1'b0; mem_wsel = 5'd0;
        mem_wbsrc = 2'd0; mem_lsize = 2'd0; mem_lsigned = 1'b0; mem_aluout = 32'd0;
        mem_dload = 32'd0; mem_pc4 = 32'd0; mem_imm16 = 16'd0; mem_halt = 1'b0;
        #1 nRST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        chk("reset rf_wen", {31'd0, rf_wen}, 32'd0);
        chk("reset rf_wdat", rf_wdat, 32'd0);
        chk("reset halt", {31'd0, halt}, 32'd0);
        chk("reset cnt", retire_cnt, 32'd0);

        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 2'd0, 2'd0, 1'b0, 32'hDEADBEEF, 32'd0, 32'd0, 16'd0, 1'b0);
        chk("alu wen", {31'd0, rf_wen}, 32'd1);
        chk("alu wsel", {27'd0, rf_wsel}, 32'd5);
        chk("alu wdat", rf_wdat, 32'hDEADBEEF);
        chk("alu cnt", retire_cnt, 32'd1);

        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 2'd1, 2'd2, 1'b1, 32'h100, LD, 32'd0, 16'd0, 1'b0);
        chk("lb lane0", rf_wdat, 32'h00000001);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 2'd1, 2'd2, 1'b1, 32'h102, LD, 32'd0, 16'd0, 1'b0);
        chk("lb lane2", rf_wdat, 32'hFFFFFFFF);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 2'd1, 2'd1, 1'b1, 32'h102, LD, 32'd0, 16'd0, 1'b0);
        chk("lh lane1 s", rf_wdat, 32'hFFFF80FF);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 2'd1, 2'd1, 1'b0, 32'h102, LD, 32'd0, 16'd0, 1'b0);
        chk("lhu lane1", rf_wdat, 32'h000080FF);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 2'd1, 2'd2, 1'b1, 32'h103, LD, 32'd0, 16'd0, 1'b0);
        chk("lb lane3", rf_wdat, 32'hFFFFFF80);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 2'd1, 2'd2, 1'b0, 32'h101, LD, 32'd0, 16'd0, 1'b0);
        chk("lbu lane1", rf_wdat, 32'h0000007F);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 2'd1, 2'd1, 1'b1, 32'h100, LD, 32'd0, 16'd0, 1'b0);
        chk("lh lane0", rf_wdat, 32'h00007F01);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 2'd1, 2'd3, 1'b1, 32'h101, LD, 32'd0, 16'd0, 1'b0);
        chk("lsize3 word", rf_wdat, LD);

        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 2'd0, 2'd0, 1'b0, 32'h1234, 32'd0, 32'd0, 16'd0, 1'b0);
        chk("r0 wen", {31'd0, rf_wen}, 32'd0);
        chk("r0 wdat", rf_wdat, 32'd0);
        chk("r0 fwd", {31'd0, fwd_valid}, 32'd0);
        chk("r0 cnt", retire_cnt, 32'd10);

        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 2'd3, 2'd0, 1'b0, 32'h0, 32'd0, 32'd0, 16'hABCD, 1'b0);
        chk("lui", rf_wdat, 32'hABCD0000);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd31, 2'd2, 2'd0, 1'b0, 32'h0, 32'd0, 32'h104, 16'd0, 1'b0);
        chk("pc4", rf_wdat, 32'h00000104);
        chk("pc4 wsel", {27'd0, rf_wsel}, 32'd31);

        issue(1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 2'd0, 2'd0, 1'b0, 32'h77, 32'd0, 32'd0, 16'd0, 1'b0);
        chk("invalid cnt", retire_cnt, 32'd12);

        issue(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 2'd0, 2'd0, 1'b0, 32'h99, 32'd0, 32'd0, 16'd0, 1'b0);
        chk("flush wen", {31'd0, rf_wen}, 32'd0);
        chk("flush cnt", retire_cnt, 32'd12);
        for (int i = 0; i < 3; i++)
            issue(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 2'd0, 2'd0, 1'b0, 32'h99, 32'd0, 32'd0, 16'd0, 1'b0);
        chk("hold bubble", {31'd0, rf_wen}, 32'd0);

        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 2'd0, 2'd0, 1'b0, 32'h55AA, 32'd0, 32'd0, 16'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            issue(1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 2'd0, 2'd0, 1'b0, 32'h1111, 32'd0, 32'd0, 16'd0, 1'b0);
        chk("hold wdat", rf_wdat, 32'h000055AA);
        chk("hold cnt", retire_cnt, 32'd13);

        issue(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 2'd0, 2'd0, 1'b0, 32'h1, 32'd0, 32'd0, 16'd0, 1'b1);
        chk("flushed halt", {31'd0, halt}, 32'd0);

        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 2'd0, 2'd0, 1'b0, 32'h1, 32'd0, 32'd0, 16'd0, 1'b1);
        chk("halt set", {31'd0, halt}, 32'd1);
        chk("halt wen", {31'd0, rf_wen}, 32'd0);
        chk("halt cnt", retire_cnt, 32'd14);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 2'd0, 2'd0, 1'b0, 32'h4444, 32'd0, 32'd0, 16'd0, 1'b0);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 2'd0, 2'd0, 1'b0, 32'h4444, 32'd0, 32'd0, 16'd0, 1'b0);
        chk("post-halt wen", {31'd0, rf_wen}, 32'd0);
        chk("post-halt cnt", retire_cnt, 32'd14);
        chk("post-halt sticky", {31'd0, halt}, 32'd1);

        #2 nRST = 1'b0;
        #1;
        chk("async halt", {31'd0, halt}, 32'd0);
        chk("async cnt", retire_cnt, 32'd0);
        chk("async wen", {31'd0, rf_wen}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 2'd0, 2'd0, 1'b0, 32'hCAFEF00D, 32'd0, 32'd0, 16'd0, 1'b0);
        chk("resume wdat", rf_wdat, 32'hCAFEF00D);
        chk("resume cnt", retire_cnt, 32'd1);

        wb_en = 1'b0;
        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
